// File: rtl/life_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : life_seq_if
//  Description : Signal bundle between the generation sequencer, its control
//                source, the life cell core and the pixel consumer.
//                master = sequencer side, slave = surrounding system side.
//  Revision    : 1.0  initial release
// ============================================================================
interface life_seq_if #(
  parameter int DIV_W = 16
) ();

  // control requests
  logic             run;
  logic             single;
  logic             dump_req;
  logic [DIV_W-1:0] period;

  // core handshake
  logic             step;
  logic             step_done;
  logic             en_out;
  logic             din;

  // pixel stream
  logic             pix_valid;
  logic             pix_data;
  logic [3:0]       pix_x;
  logic [3:0]       pix_y;
  logic             frame_end;

  // status
  logic [DIV_W-1:0] gen;
  logic             busy;
  logic             err;

  modport master (
    input  run, single, dump_req, period, step_done, din,
    output step, en_out, pix_valid, pix_data, pix_x, pix_y, frame_end,
           gen, busy, err
  );

  modport slave (
    output run, single, dump_req, period, step_done, din,
    input  step, en_out, pix_valid, pix_data, pix_x, pix_y, frame_end,
           gen, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/life_seq.sv
`default_nettype none
// ============================================================================
//  Module      : life_seq
//  Description : Generation sequencer for the 13x13 life core. Issues step
//                pulses on request or on a programmable period, opens the
//                core's serial readout window and turns the returned bit
//                stream into raster-ordered pixel beats with coordinates.
//  Revision    : 1.0  initial release
// ============================================================================
module life_seq #(
  parameter int W        = 13,
  parameter int H        = 13,
  parameter int CELLS    = W * H,
  parameter int DIV_W    = 16,
  parameter int STEP_TMO = 1024
) (
  input  logic       clk,
  input  logic       rst,
  life_seq_if.master bus
);

  // One shared per-state counter serves the step timeout, the readout
  // window length and the drain length, so it must hold the larger of them.
  localparam int c_CNT_MAX = (STEP_TMO > CELLS) ? STEP_TMO : CELLS;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_TMO_LAST   = c_CNT_W'(STEP_TMO - 1);
  localparam logic [c_CNT_W-1:0] c_CELL_LAST  = c_CNT_W'(CELLS - 1);
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(1);
  localparam logic [3:0]         c_X_LAST     = 4'(W - 1);
  localparam logic [3:0]         c_Y_LAST     = 4'(H - 1);
  localparam logic [DIV_W-1:0]   c_WAIT_LAST  = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_DUMP  = 3'd2,
    S_DRAIN = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_tmo;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0]   r_wait;
  logic [DIV_W-1:0]   r_gen;
  logic               r_step;
  logic               r_err;

  logic               r_en_d1;
  logic               r_pix_valid;
  logic               r_pix_data;
  logic [3:0]         r_pix_x;
  logic [3:0]         r_pix_y;
  logic               r_frame_end;
  logic [3:0]         r_col;
  logic [3:0]         r_row;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; requests are only looked at in IDLE, so anything
  // arriving in other states is simply dropped rather than queued.
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run || bus.single) begin
          w_next = S_STEP;
        end else if (bus.dump_req) begin
          w_next = S_DUMP;
        end
      end
      S_STEP: begin
        if (bus.step_done) begin
          w_next = S_DUMP;
        end else if (r_cnt == c_TMO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_DUMP: begin
        if (r_cnt == c_CELL_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_DRAIN_LAST) begin
          if (!bus.run) begin
            w_next = S_IDLE;
          end else if (bus.period == '0) begin
            w_next = S_STEP;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.run) begin
          w_next = S_IDLE;
        end else if (r_wait <= c_WAIT_LAST) begin
          w_next = S_STEP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Per-state cycle counter: restarts on every transition, parked in IDLE/WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_WAIT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Inter-frame wait counter: period captured on WAIT entry, counts down to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if ((r_state == S_DRAIN) && (w_next == S_WAIT)) begin
      r_wait <= bus.period;
    end else if (r_state == S_WAIT) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  // Step pulse: registered so it is high for exactly the first STEP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= 1'b0;
    end else begin
      r_step <= (w_next == S_STEP) && (r_state != S_STEP);
    end
  end

  // Generation count and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gen <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == S_STEP) && bus.step_done) begin
        r_gen <= r_gen + 1'b1;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  // Readout pipeline: en_out delayed once marks the cycle din is valid,
  // delayed twice it becomes the pixel beat carrying the registered din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_d1     <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= 1'b0;
    end else begin
      r_en_d1     <= (r_state == S_DUMP);
      r_pix_valid <= r_en_d1;
      r_pix_data  <= r_en_d1 & bus.din;
    end
  end

  // Raster coordinates: r_col/r_row point at the next beat, the pix_x/pix_y
  // outputs carry the current beat and rest at (0,0) between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_frame_end <= 1'b0;
    end else if (r_en_d1) begin
      r_pix_x     <= r_col;
      r_pix_y     <= r_row;
      r_frame_end <= (r_col == c_X_LAST) && (r_row == c_Y_LAST);
      if (r_col == c_X_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_Y_LAST) ? 4'd0 : r_row + 4'd1;
      end else begin
        r_col <= r_col + 4'd1;
      end
    end else begin
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_frame_end <= 1'b0;
    end
  end

  // en_out and busy decode straight from the state register, so an
  // asynchronous reset drops them in the same cycle.
  assign bus.en_out    = (r_state == S_DUMP);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.step      = r_step;
  assign bus.gen       = r_gen;
  assign bus.err       = r_err;
  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_data  = r_pix_data;
  assign bus.pix_x     = r_pix_x;
  assign bus.pix_y     = r_pix_y;
  assign bus.frame_end = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_life_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_seq
//  Description : Self-checking bench for life_seq with a behavioural core
//                model (grid readout, delayed step_done) and a frame model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_seq;

  localparam int W        = 13;
  localparam int H        = 13;
  localparam int CELLS    = W * H;
  localparam int DIV_W    = 16;
  localparam int STEP_TMO = 1024;

  typedef struct packed {
    logic       fe;
    logic       d;
    logic [3:0] y;
    logic [3:0] x;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  life_seq_if #(.DIV_W(DIV_W)) bus ();

  life_seq #(
    .W(W), .H(H), .CELLS(CELLS), .DIV_W(DIV_W), .STEP_TMO(STEP_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // core model state
  bit grid [CELLS];
  int done_delay = 5;
  int stray_at   = -1;

  // reference state
  logic [DIV_W-1:0] model_gen = '0;
  logic             model_err = 1'b0;

  // observations
  int    step_cyc[$];
  beat_t beats[$];
  int    en_cnt;
  int    first_en;
  int    last_beat_cyc;
  int    last_busy_cyc;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Core model (readout + step response) and output monitor, all at negedge
  initial begin
    int idx;
    bit en_prev;
    int done_cnt;
    idx = 0; en_prev = 0; done_cnt = -1;
    bus.din = 1'b0; bus.step_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idx = 0; en_prev = 0; done_cnt = -1;
        bus.din = 1'b0; bus.step_done = 1'b0;
      end else begin
        if (en_prev) begin
          bus.din = grid[idx];
          idx = (idx == CELLS - 1) ? 0 : idx + 1;
        end else begin
          bus.din = 1'b0;
        end
        en_prev = bus.en_out;
        bus.step_done = 1'b0;
        if (bus.step && done_delay >= 0) begin
          if (done_delay == 0) bus.step_done = 1'b1;
          else done_cnt = done_delay - 1;
        end else if (done_cnt == 0) begin
          bus.step_done = 1'b1;
          done_cnt = -1;
        end else if (done_cnt > 0) begin
          done_cnt = done_cnt - 1;
        end
        if (cyc == stray_at) bus.step_done = 1'b1;
      end
      if (bus.step) step_cyc.push_back(cyc);
      if (bus.en_out) begin
        if (en_cnt == 0) first_en = cyc;
        en_cnt = en_cnt + 1;
      end
      if (bus.pix_valid) begin
        beats.push_back({bus.frame_end, bus.pix_data, bus.pix_y, bus.pix_x});
        last_beat_cyc = cyc;
      end
      if (bus.busy) last_busy_cyc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    step_cyc.delete();
    beats.delete();
    en_cnt = 0; first_en = -1; last_beat_cyc = -1; last_busy_cyc = -1;
  endtask

  task automatic randomize_grid();
    for (int i = 0; i < CELLS; i++) grid[i] = 1'($urandom_range(0, 1));
  endtask

  // Request inputs held for one cycle; rc is the cycle right after the sampling edge
  task automatic pulse_req(input bit s, input bit d, output int rc);
    @(posedge clk); #1;
    bus.single = s; bus.dump_req = d;
    @(posedge clk); #1;
    bus.single = 1'b0; bus.dump_req = 1'b0;
    rc = cyc;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Number of beats in the frame starting at 'base' that differ from the
  // raster model: beat i -> (i mod W, i div W), data = grid[i], end at CELLS-1
  function automatic int frame_bad(input int base);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      beat_t b;
      b = beats[base + i];
      if (b.x !== 4'(i % W) || b.y !== 4'(i / W) ||
          b.d !== logic'(grid[i]) || b.fe !== logic'(i == CELLS - 1)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.step, bus.en_out, bus.pix_valid, bus.pix_data, bus.frame_end, bus.busy, bus.err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000",
               {bus.step, bus.en_out, bus.pix_valid, bus.pix_data, bus.frame_end, bus.busy, bus.err});
    end
    checks++;
    if (bus.pix_x !== 4'd0 || bus.pix_y !== 4'd0 || bus.gen !== '0) begin
      errors++;
      $display("FAIL reset_values: x=%0d y=%0d gen=%0d want 0 0 0", bus.pix_x, bus.pix_y, bus.gen);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_gen = '0; model_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.step !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b step=%b want 0 0", bus.busy, bus.step);
    end
  endtask

  task automatic test_single(input int delay, input string tag);
    int rc;
    bit ok;
    randomize_grid();
    done_delay = delay;
    clear_mon();
    pulse_req(1'b1, 1'b0, rc);
    checks++;
    if (bus.step !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s step_entry: step=%b busy=%b want 1 1", tag, bus.step, bus.busy);
    end
    wait_idle(CELLS + delay + 50, ok);
    model_gen = model_gen + 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s idle_return: busy=%b want 0", tag, bus.busy);
    end
    checks++;
    if (step_cyc.size() != 1 || step_cyc[0] != rc) begin
      errors++;
      $display("FAIL %s step_pulses: count=%0d want 1 at cycle %0d", tag, step_cyc.size(), rc);
    end
    checks++;
    if (en_cnt != CELLS || first_en != rc + delay + 1) begin
      errors++;
      $display("FAIL %s en_out_window: len=%0d start=%0d want %0d at %0d",
               tag, en_cnt, first_en, CELLS, rc + delay + 1);
    end
    checks++;
    if (beats.size() != CELLS || frame_bad(0) != 0) begin
      errors++;
      $display("FAIL %s frame: beats=%0d bad=%0d want %0d 0", tag, beats.size(),
               (beats.size() >= CELLS) ? frame_bad(0) : -1, CELLS);
    end
    checks++;
    if (bus.gen !== model_gen || bus.err !== model_err) begin
      errors++;
      $display("FAIL %s status: gen=%0d err=%b want %0d %b", tag, bus.gen, bus.err, model_gen, model_err);
    end
    checks++;
    if (last_busy_cyc != last_beat_cyc) begin
      errors++;
      $display("FAIL %s busy_fall: last busy %0d want %0d", tag, last_busy_cyc, last_beat_cyc);
    end
  endtask

  task automatic test_dump_pattern();
    int    rc;
    bit    ok;
    longint found;
    for (int i = 0; i < CELLS; i++) grid[i] = 1'b0;
    grid[3] = 1'b1; grid[4] = 1'b1; grid[18] = 1'b1;
    clear_mon();
    pulse_req(1'b0, 1'b1, rc);
    stray_at = rc + 30;
    checks++;
    if (bus.en_out !== 1'b1 || bus.step !== 1'b0) begin
      errors++;
      $display("FAIL dump_entry: en_out=%b step=%b want 1 0", bus.en_out, bus.step);
    end
    wait_idle(CELLS + 40, ok);
    stray_at = -1;
    checks++;
    if (!ok || step_cyc.size() != 0 || en_cnt != CELLS || first_en != rc) begin
      errors++;
      $display("FAIL dump_window: idle=%b steps=%0d len=%0d start=%0d want 1 0 %0d %0d",
               ok, step_cyc.size(), en_cnt, first_en, CELLS, rc);
    end
    found = 0;
    foreach (beats[i]) if (beats[i].d) found = found * 256 + longint'({beats[i].y, beats[i].x});
    checks++;
    if (beats.size() != CELLS || found != ((longint'(8'h03) * 256 + 8'h04) * 256 + 8'h15)) begin
      errors++;
      $display("FAIL dump_alive_cells: beats=%0d cells=%h want %0d 030415", beats.size(), found, CELLS);
    end
    checks++;
    if (bus.gen !== model_gen) begin
      errors++;
      $display("FAIL dump_gen: gen=%0d want %0d", bus.gen, model_gen);
    end
  endtask

  task automatic test_dump_random();
    int rc;
    bit ok;
    randomize_grid();
    clear_mon();
    pulse_req(1'b0, 1'b1, rc);
    wait_idle(CELLS + 40, ok);
    checks++;
    if (!ok || beats.size() != CELLS || frame_bad(0) != 0 || step_cyc.size() != 0) begin
      errors++;
      $display("FAIL dump_random: idle=%b beats=%0d steps=%0d want 1 %0d 0",
               ok, beats.size(), step_cyc.size(), CELLS);
    end
  endtask

  task automatic test_run(input int p, input int d, input int n);
    bit reached;
    bit ok;
    int bad_gap;
    int bad_pix;
    randomize_grid();
    done_delay = d;
    clear_mon();
    bus.period = DIV_W'(p);
    @(posedge clk); #1;
    bus.run = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < n * (CELLS + d + p + 200); i++) begin
      @(posedge clk); #1;
      if (step_cyc.size() >= n && bus.en_out && en_cnt >= (n - 1) * CELLS + 40) begin
        reached = 1'b1;
        break;
      end
    end
    bus.run = 1'b0;
    wait_idle(CELLS + 20, ok);
    model_gen = model_gen + DIV_W'(n);
    checks++;
    if (!reached || !ok) begin
      errors++;
      $display("FAIL run_p%0d progress: reached=%b idle=%b want 1 1", p, reached, ok);
    end
    bad_gap = 0;
    for (int i = 1; i < step_cyc.size(); i++)
      if (step_cyc[i] - step_cyc[i-1] != d + 1 + CELLS + 2 + p) bad_gap++;
    checks++;
    if (step_cyc.size() != n || bad_gap != 0) begin
      errors++;
      $display("FAIL run_p%0d step_spacing: steps=%0d bad_gaps=%0d want %0d 0 (gap %0d)",
               p, step_cyc.size(), bad_gap, n, d + 1 + CELLS + 2 + p);
    end
    bad_pix = 0;
    if (beats.size() == n * CELLS)
      for (int f = 0; f < n; f++) bad_pix += frame_bad(f * CELLS);
    checks++;
    if (en_cnt != n * CELLS || beats.size() != n * CELLS || bad_pix != 0) begin
      errors++;
      $display("FAIL run_p%0d frames: en=%0d beats=%0d bad=%0d want %0d %0d 0",
               p, en_cnt, beats.size(), bad_pix, n * CELLS, n * CELLS);
    end
    checks++;
    if (bus.gen !== model_gen || last_busy_cyc != last_beat_cyc) begin
      errors++;
      $display("FAIL run_p%0d end: gen=%0d lastbusy=%0d want %0d %0d",
               p, bus.gen, last_busy_cyc, model_gen, last_beat_cyc);
    end
  endtask

  task automatic test_wait_drop();
    bit reached;
    randomize_grid();
    done_delay = 2;
    clear_mon();
    bus.period = DIV_W'(60);
    @(posedge clk); #1;
    bus.run = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < CELLS + 100; i++) begin
      @(posedge clk); #1;
      if (beats.size() >= CELLS) begin
        reached = 1'b1;
        break;
      end
    end
    repeat (5) @(posedge clk);
    #1;
    bus.run = 1'b0;
    @(posedge clk); #1;
    model_gen = model_gen + 1'b1;
    checks++;
    if (!reached || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_drop: reached=%b busy=%b want 1 0", reached, bus.busy);
    end
    repeat (80) @(posedge clk);
    #1;
    checks++;
    if (step_cyc.size() != 1 || bus.gen !== model_gen) begin
      errors++;
      $display("FAIL wait_drop_nostep: steps=%0d gen=%0d want 1 %0d", step_cyc.size(), bus.gen, model_gen);
    end
  endtask

  task automatic test_timeout();
    int rc;
    bit ok;
    done_delay = -1;
    clear_mon();
    pulse_req(1'b1, 1'b0, rc);
    wait_idle(STEP_TMO + 20, ok);
    model_err = 1'b1;
    checks++;
    if (!ok || last_busy_cyc - rc + 1 != STEP_TMO) begin
      errors++;
      $display("FAIL timeout_len: idle=%b step_cycles=%0d want 1 %0d", ok, last_busy_cyc - rc + 1, STEP_TMO);
    end
    checks++;
    if (bus.err !== 1'b1 || en_cnt != 0 || step_cyc.size() != 1 || bus.gen !== model_gen) begin
      errors++;
      $display("FAIL timeout_state: err=%b en=%0d steps=%0d gen=%0d want 1 0 1 %0d",
               bus.err, en_cnt, step_cyc.size(), bus.gen, model_gen);
    end
    test_single(3, "after_tmo");
  endtask

  task automatic test_reset_mid();
    int rc;
    bit reached;
    randomize_grid();
    done_delay = 2;
    clear_mon();
    pulse_req(1'b1, 1'b0, rc);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.en_out && en_cnt == 49) begin
        reached = 1'b1;
        break;
      end
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (!reached || bus.en_out !== 1'b0 || bus.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_drop: reached=%b en_out=%b pix_valid=%b want 1 0 0",
               reached, bus.en_out, bus.pix_valid);
    end
    checks++;
    if ({bus.step, bus.pix_data, bus.frame_end, bus.busy, bus.err} !== 5'b0 ||
        bus.pix_x !== 4'd0 || bus.pix_y !== 4'd0 || bus.gen !== '0) begin
      errors++;
      $display("FAIL rst_mid_values: flags=%b x=%0d y=%0d gen=%0d want 00000 0 0 0",
               {bus.step, bus.pix_data, bus.frame_end, bus.busy, bus.err}, bus.pix_x, bus.pix_y, bus.gen);
    end
    model_gen = '0;
    model_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    test_single(5, "after_rst");
  endtask

  task automatic test_wrap();
    int rc;
    int rc2;
    bit reached;
    bit ok;
    @(negedge clk);
    force dut.r_gen = '1;
    @(negedge clk);
    release dut.r_gen;
    model_gen = '1;
    randomize_grid();
    done_delay = 4;
    clear_mon();
    pulse_req(1'b1, 1'b0, rc);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (en_cnt >= 60) begin
        reached = 1'b1;
        break;
      end
    end
    pulse_req(1'b1, 1'b1, rc2);
    wait_idle(CELLS + 40, ok);
    model_gen = model_gen + 1'b1;
    checks++;
    if (bus.gen !== model_gen) begin
      errors++;
      $display("FAIL gen_wrap: gen=%0d want %0d", bus.gen, model_gen);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (!reached || !ok || step_cyc.size() != 1 || en_cnt != CELLS || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dump_requests_dropped: steps=%0d en=%0d busy=%b want 1 %0d 0",
               step_cyc.size(), en_cnt, bus.busy, CELLS);
    end
    checks++;
    if (beats.size() != CELLS || frame_bad(0) != 0) begin
      errors++;
      $display("FAIL wrap_frame: beats=%0d want %0d clean", beats.size(), CELLS);
    end
  endtask

  task automatic test_back_to_back();
    int rc;
    int rc2;
    bit ok;
    bit ok2;
    int bad_pix;
    randomize_grid();
    done_delay = int'($urandom_range(0, 8));
    clear_mon();
    pulse_req(1'b1, 1'b1, rc);
    checks++;
    if (bus.step !== 1'b1 || bus.en_out !== 1'b0) begin
      errors++;
      $display("FAIL priority_single: step=%b en_out=%b want 1 0", bus.step, bus.en_out);
    end
    wait_idle(CELLS + 50, ok);
    model_gen = model_gen + 1'b1;
    pulse_req(1'b0, 1'b1, rc2);
    wait_idle(CELLS + 50, ok2);
    bad_pix = 0;
    if (beats.size() == 2 * CELLS) bad_pix = frame_bad(0) + frame_bad(CELLS);
    checks++;
    if (!ok || !ok2 || step_cyc.size() != 1 || beats.size() != 2 * CELLS || bad_pix != 0 ||
        bus.gen !== model_gen) begin
      errors++;
      $display("FAIL back_to_back: steps=%0d beats=%0d bad=%0d gen=%0d want 1 %0d 0 %0d",
               step_cyc.size(), beats.size(), bad_pix, bus.gen, 2 * CELLS, model_gen);
    end
  endtask

  initial begin
    bus.run = 1'b0;
    bus.single = 1'b0;
    bus.dump_req = 1'b0;
    bus.period = '0;
    test_reset();
    test_single(5, "single_d5");
    test_single(int'($urandom_range(0, 12)), "single_rnd");
    test_dump_pattern();
    test_dump_random();
    test_run(10, 5, 3);
    test_run(0, int'($urandom_range(0, 6)), 2);
    test_run(int'($urandom_range(1, 30)), int'($urandom_range(0, 6)), 2);
    test_wait_drop();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
